// File: rtl/lpif_txrx_x4_asym2_quarter_master_gearbox_if.sv
// Bus bundle for the x4 asym2 quarter-rate master gearbox.
// Optional macro LPIF_QTR_TX_FLUSH_EN adds the tx_flush request signal.
// The master modport is the gearbox view; the slave modport is its environment.
interface lpif_txrx_x4_asym2_quarter_master_gearbox_if #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 77
);
    logic [BEAT_W-1:0]       up_beat_data;
    logic                    up_beat_vld;
    logic                    up_beat_rdy;
    logic [BEATS*BEAT_W-1:0] txfifo_upstream_data;
    logic                    txfifo_upstream_vld;
    logic                    txfifo_upstream_rdy;
    logic [BEATS*BEAT_W-1:0] rxfifo_downstream_data;
    logic                    rxfifo_downstream_vld;
    logic                    rxfifo_downstream_rdy;
    logic [BEAT_W-1:0]       dn_beat_data;
    logic                    dn_beat_vld;
    logic                    dn_beat_rdy;
    logic [1:0]              tx_beat_cnt;
    logic [1:0]              rx_beat_idx;
`ifdef LPIF_QTR_TX_FLUSH_EN
    logic                    tx_flush;
`endif

    modport master (
`ifdef LPIF_QTR_TX_FLUSH_EN
        input  tx_flush,
`endif
        input  up_beat_data, up_beat_vld, txfifo_upstream_rdy,
        input  rxfifo_downstream_data, rxfifo_downstream_vld, dn_beat_rdy,
        output up_beat_rdy, txfifo_upstream_data, txfifo_upstream_vld,
        output rxfifo_downstream_rdy, dn_beat_data, dn_beat_vld,
        output tx_beat_cnt, rx_beat_idx
    );

    modport slave (
`ifdef LPIF_QTR_TX_FLUSH_EN
        output tx_flush,
`endif
        output up_beat_data, up_beat_vld, txfifo_upstream_rdy,
        output rxfifo_downstream_data, rxfifo_downstream_vld, dn_beat_rdy,
        input  up_beat_rdy, txfifo_upstream_data, txfifo_upstream_vld,
        input  rxfifo_downstream_rdy, dn_beat_data, dn_beat_vld,
        input  tx_beat_cnt, rx_beat_idx
    );
endinterface

// File: rtl/lpif_txrx_x4_asym2_quarter_master_gearbox.sv
// Master-side rate gearbox for the x4 asym2 quarter-rate LPIF link.
// TX packs four 77-bit beats into one 308-bit FIFO word; RX unpacks each
// 308-bit FIFO word back into four beats, beat k at [77k +: 77].
// Optional macro LPIF_QTR_TX_FLUSH_EN enables zero-padded flush of a partial TX word.
module lpif_txrx_x4_asym2_quarter_master_gearbox #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 77
) (
    input logic lclk,
    input logic rst,
    lpif_txrx_x4_asym2_quarter_master_gearbox_if.master bus
);
    localparam int WORD_W = BEATS * BEAT_W;

    logic [1:0]        r_tx_cnt;
    logic [BEAT_W-1:0] r_stage [0:BEATS-2];
    logic [WORD_W-1:0] r_tx_word;
    logic              r_tx_vld;
    logic [WORD_W-1:0] r_rx_word;
    logic              r_rx_loaded;
    logic [1:0]        r_rx_idx;

    logic              w_tx_hold;
    logic              w_tx_rdy;
    logic              w_tx_fire;
    logic              w_tx_load;
    logic [WORD_W-1:0] w_tx_word;
    logic              w_rx_rdy;
    logic              w_rx_take;

    // Output register is occupied and the FIFO refuses it this cycle
    assign w_tx_hold = r_tx_vld && !bus.txfifo_upstream_rdy;
    assign w_tx_fire = bus.up_beat_vld && w_tx_rdy;

`ifdef LPIF_QTR_TX_FLUSH_EN
    logic r_flush_pend;
    logic w_flush_any;
    logic w_flush_go;

    // A flush seen while the output register is held is remembered until it can load
    assign w_flush_any = bus.tx_flush || r_flush_pend;
    assign w_tx_rdy    = !(r_tx_cnt == 2'd3 && w_tx_hold) && !(w_flush_any && w_tx_hold);
    assign w_flush_go  = w_flush_any && (r_tx_cnt != 2'd0 || w_tx_fire) && !w_tx_hold;
    assign w_tx_load   = (w_tx_fire && r_tx_cnt == 2'd3) || w_flush_go;

    // Track a stalled flush request with a partial word behind it
    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_go) begin
            r_flush_pend <= 1'b0;
        end else if (bus.tx_flush && w_tx_hold && r_tx_cnt != 2'd0) begin
            r_flush_pend <= 1'b1;
        end
    end
`else
    assign w_tx_rdy  = !(r_tx_cnt == 2'd3 && w_tx_hold);
    assign w_tx_load = w_tx_fire && r_tx_cnt == 2'd3;
`endif

    // Assemble the outgoing word: filled staging slots, the incoming beat, zeros beyond
    always_comb begin
        w_tx_word = '0;
        for (int k = 0; k < BEATS - 1; k++) begin
            if (k < int'(r_tx_cnt)) begin
                w_tx_word[k*BEAT_W +: BEAT_W] = r_stage[k];
            end
        end
        if (w_tx_fire) begin
            w_tx_word[int'(r_tx_cnt)*BEAT_W +: BEAT_W] = bus.up_beat_data;
        end
    end

    // TX staging, beat counter and held output word
    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            r_tx_cnt  <= 2'd0;
            r_tx_word <= '0;
            r_tx_vld  <= 1'b0;
            for (int k = 0; k < BEATS - 1; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            if (w_tx_fire && r_tx_cnt != 2'd3) begin
                r_stage[r_tx_cnt] <= bus.up_beat_data;
            end
            if (w_tx_load) begin
                r_tx_cnt <= 2'd0;
            end else if (w_tx_fire) begin
                r_tx_cnt <= r_tx_cnt + 2'd1;
            end
            if (w_tx_load) begin
                r_tx_word <= w_tx_word;
                r_tx_vld  <= 1'b1;
            end else if (bus.txfifo_upstream_rdy) begin
                r_tx_vld  <= 1'b0;
            end
        end
    end

    // RX word accepted when empty, or when the last beat leaves this cycle; never during reset
    assign w_rx_rdy  = !rst && (!r_rx_loaded || (r_rx_idx == 2'd3 && bus.dn_beat_rdy));
    assign w_rx_take = bus.rxfifo_downstream_vld && w_rx_rdy;

    // RX word register and beat index
    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            r_rx_word   <= '0;
            r_rx_loaded <= 1'b0;
            r_rx_idx    <= 2'd0;
        end else if (w_rx_take) begin
            r_rx_word   <= bus.rxfifo_downstream_data;
            r_rx_loaded <= 1'b1;
            r_rx_idx    <= 2'd0;
        end else if (r_rx_loaded && bus.dn_beat_rdy) begin
            r_rx_idx <= r_rx_idx + 2'd1;
            if (r_rx_idx == 2'd3) begin
                r_rx_loaded <= 1'b0;
            end
        end
    end

    assign bus.up_beat_rdy           = w_tx_rdy;
    assign bus.txfifo_upstream_data  = r_tx_word;
    assign bus.txfifo_upstream_vld   = r_tx_vld;
    assign bus.tx_beat_cnt           = r_tx_cnt;
    assign bus.rxfifo_downstream_rdy = w_rx_rdy;
    assign bus.dn_beat_vld           = r_rx_loaded;
    assign bus.dn_beat_data          = r_rx_loaded ? r_rx_word[int'(r_rx_idx)*BEAT_W +: BEAT_W] : '0;
    assign bus.rx_beat_idx           = r_rx_idx;
endmodule
